srl_fifo_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/srl_fifo_storage.sv | 28 ++
 rtl/srl_fifo_ctrl.sv | 94 +++++++++
 tb/tb_srl_fifo_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the SRL dataflow channels.
// Occupancy width helper, flag reset values, channel defaults.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_DEPTH      = 2;

  localparam logic RST_EMPTY_N = 1'b0;
  localparam logic RST_FULL_N  = 1'b1;
  localparam logic RST_ERR     = 1'b0;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/srl_fifo_storage.sv
// Pure SRL shift array: entry 0 takes din on we, others shift up.
// Ports: clk, we, addr (read index), din, dout (combinational read).
module srl_fifo_storage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// FWFT SRL FIFO controller: count, registered flags, sticky errors.
// Ports: write side (ce/write/din/full_n), read side (ce/read/dout/empty_n),
// almost_full, count, wr_err, rd_err; sync active-high reset.
module srl_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);
  localparam logic          AF_RST  = (AF_MARGIN >= DEPTH);

  if (DEPTH > (1 << ADDR_WIDTH) || DEPTH < 2 ||
      occ_width(DEPTH) > CW) begin : g_bad_depth
    $error("srl_fifo_ctrl: DEPTH must be in 2..2**ADDR_WIDTH");
  end

  logic            push;
  logic            pop;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_next;
  logic [ADDR_WIDTH-1:0] addr;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read & if_read_ce & if_empty_n;

  always_comb begin
    count_next = count_q;
    unique case ({push, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Low bits minus one is exact even at count == 2**ADDR_WIDTH.
  assign addr = (count_q == '0) ? '0
              : count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      if_empty_n  <= RST_EMPTY_N;
      if_full_n   <= RST_FULL_N;
      almost_full <= AF_RST;
      wr_err      <= RST_ERR;
      rd_err      <= RST_ERR;
    end else begin
      count_q     <= count_next;
      if_empty_n  <= (count_next != '0);
      if_full_n   <= (count_next != DEPTH_C);
      almost_full <= (count_next >= AF_TH);
      if (if_write & if_write_ce & ~if_full_n)
        wr_err <= 1'b1;
      if (if_read & if_read_ce & ~if_empty_n)
        rd_err <= 1'b1;
    end
  end

  assign count = count_q;

  srl_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .addr (addr),
    .din  (if_din),
    .dout (if_dout)
  );

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Bench for srl_fifo_ctrl: DEPTH=2 instance (a) and DEPTH=4 instance (b).
// Queue scoreboard holds expected FIFO contents for each instance.
module tb_srl_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Instance a: DEPTH=2, ADDR_WIDTH=1, DATA_WIDTH=1, AF_MARGIN=1
  logic       a_reset = 1'b1;
  logic       a_wce = 1'b0, a_w = 1'b0, a_rce = 1'b0, a_r = 1'b0;
  logic [0:0] a_din = '0;
  logic [0:0] a_dout;
  logic       a_full_n, a_empty_n, a_af, a_wr_err, a_rd_err;
  logic [1:0] a_count;

  // Instance b: DEPTH=4, ADDR_WIDTH=2, DATA_WIDTH=8, AF_MARGIN=1
  logic       b_reset = 1'b1;
  logic       b_wce = 1'b0, b_w = 1'b0, b_rce = 1'b0, b_r = 1'b0;
  logic [7:0] b_din = '0;
  logic [7:0] b_dout;
  logic       b_full_n, b_empty_n, b_af, b_wr_err, b_rd_err;
  logic [2:0] b_count;

  srl_fifo_ctrl #(
    .DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2), .AF_MARGIN(1)
  ) dut_a (
    .clk(clk), .reset(a_reset),
    .if_write_ce(a_wce), .if_write(a_w), .if_din(a_din),
    .if_full_n(a_full_n),
    .if_read_ce(a_rce), .if_read(a_r), .if_dout(a_dout),
    .if_empty_n(a_empty_n), .almost_full(a_af), .count(a_count),
    .wr_err(a_wr_err), .rd_err(a_rd_err)
  );

  srl_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AF_MARGIN(1)
  ) dut_b (
    .clk(clk), .reset(b_reset),
    .if_write_ce(b_wce), .if_write(b_w), .if_din(b_din),
    .if_full_n(b_full_n),
    .if_read_ce(b_rce), .if_read(b_r), .if_dout(b_dout),
    .if_empty_n(b_empty_n), .almost_full(b_af), .count(b_count),
    .wr_err(b_wr_err), .rd_err(b_rd_err)
  );

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit ewr_a, erd_a, ewr_b, erd_b;

  task automatic step_a(input logic w, input logic d, input logic r,
                        input logic wce, input logic rce,
                        output bit popped, output logic [7:0] exp,
                        output logic [7:0] act);
    bit pu, po;
    @(negedge clk);
    a_w = w; a_din = d; a_r = r; a_wce = wce; a_rce = rce;
    pu = w && wce && (qa.size() < 2);
    po = r && rce && (qa.size() > 0);
    if (w && wce && qa.size() == 2) ewr_a = 1'b1;
    if (r && rce && qa.size() == 0) erd_a = 1'b1;
    popped = po;
    exp = po ? qa[0] : 8'h00;
    #1 act = {7'b0, a_dout};
    @(posedge clk); #1;
    if (po) void'(qa.pop_front());
    if (pu) qa.push_back({7'b0, d});
    a_w = 1'b0; a_r = 1'b0;
  endtask

  task automatic step_b(input logic w, input logic [7:0] d, input logic r,
                        output bit popped, output logic [7:0] exp,
                        output logic [7:0] act);
    bit pu, po;
    @(negedge clk);
    b_w = w; b_din = d; b_r = r; b_wce = 1'b1; b_rce = 1'b1;
    pu = w && (qb.size() < 4);
    po = r && (qb.size() > 0);
    if (w && qb.size() == 4) ewr_b = 1'b1;
    if (r && qb.size() == 0) erd_b = 1'b1;
    popped = po;
    exp = po ? qb[0] : 8'h00;
    #1 act = b_dout;
    @(posedge clk); #1;
    if (po) void'(qb.pop_front());
    if (pu) qb.push_back(d);
    b_w = 1'b0; b_r = 1'b0;
  endtask

  task automatic reset_both();
    @(negedge clk);
    a_reset = 1'b1; b_reset = 1'b1;
    @(posedge clk); #1;
    a_reset = 1'b0; b_reset = 1'b0;
    qa.delete(); qb.delete();
    ewr_a = 0; erd_a = 0; ewr_b = 0; erd_b = 0;
  endtask

  task automatic test_reset();
    reset_both();
    checks++; if (a_count !== 2'd0) $display("FAIL rst_count got %0d want 0", a_count); else passed++;
    checks++; if (a_empty_n !== 1'b0) $display("FAIL rst_empty_n got %b want 0", a_empty_n); else passed++;
    checks++; if (a_full_n !== 1'b1) $display("FAIL rst_full_n got %b want 1", a_full_n); else passed++;
    checks++; if ({a_af, a_wr_err, a_rd_err} !== 3'b000) $display("FAIL rst_af_err got %b want 000", {a_af, a_wr_err, a_rd_err}); else passed++;
    checks++; if ({b_count, b_af, b_full_n, b_empty_n} !== 6'b000010) $display("FAIL rst_b got %b want 000010", {b_count, b_af, b_full_n, b_empty_n}); else passed++;
  endtask

  task automatic test_fill();
    bit p; logic [7:0] e, v;
    step_a(1, 1'b1, 0, 1, 1, p, e, v);
    checks++; if (a_count !== 2'd1) $display("FAIL fill1_count got %0d want 1", a_count); else passed++;
    checks++; if ({a_empty_n, a_full_n} !== 2'b11) $display("FAIL fill1_flags got %b want 11", {a_empty_n, a_full_n}); else passed++;
    checks++; if (a_dout !== 1'b1) $display("FAIL fill1_dout got %b want 1", a_dout); else passed++;
    step_a(1, 1'b0, 0, 1, 1, p, e, v);
    checks++; if (a_count !== 2'd2) $display("FAIL fill2_count got %0d want 2", a_count); else passed++;
    checks++; if (a_full_n !== 1'b0) $display("FAIL fill2_full_n got %b want 0", a_full_n); else passed++;
    checks++; if (a_dout !== 1'b1) $display("FAIL fill2_dout got %b want 1", a_dout); else passed++;
    step_a(1, 1'b1, 0, 1, 1, p, e, v);
    checks++; if (a_wr_err !== 1'b1) $display("FAIL fill3_wr_err got %b want 1", a_wr_err); else passed++;
    checks++; if (a_count !== 2'd2) $display("FAIL fill3_count got %0d want 2", a_count); else passed++;
  endtask

  task automatic test_drain();
    bit p; logic [7:0] e, v;
    step_a(0, 1'b0, 1, 1, 1, p, e, v);
    checks++; if (!p || v !== e || e !== 8'd1) $display("FAIL drain1_dout got %0d want %0d (1)", v, e); else passed++;
    checks++; if ({a_count, a_full_n, a_empty_n} !== 4'b0111) $display("FAIL drain1_state got %b want 0111", {a_count, a_full_n, a_empty_n}); else passed++;
    step_a(0, 1'b0, 1, 1, 1, p, e, v);
    checks++; if (!p || v !== e || e !== 8'd0) $display("FAIL drain2_dout got %0d want %0d (0)", v, e); else passed++;
    checks++; if ({a_count, a_empty_n} !== 3'b000) $display("FAIL drain2_state got %b want 000", {a_count, a_empty_n}); else passed++;
  endtask

  task automatic test_simul();
    bit p; logic [7:0] e, v;
    step_a(1, 1'b1, 0, 1, 1, p, e, v);
    step_a(1, 1'b0, 1, 1, 1, p, e, v);
    checks++; if (!p || v !== e || e !== 8'd1) $display("FAIL simul_pop got %0d want %0d", v, e); else passed++;
    checks++; if (a_count !== 2'd1) $display("FAIL simul_count got %0d want 1", a_count); else passed++;
    checks++; if (a_dout !== qa[0][0] || a_dout !== 1'b0) $display("FAIL simul_dout got %b want 0", a_dout); else passed++;
    checks++; if ({a_empty_n, a_full_n, a_af} !== 3'b111) $display("FAIL simul_flags got %b want 111", {a_empty_n, a_full_n, a_af}); else passed++;
    step_a(0, 1'b0, 1, 1, 1, p, e, v);
    checks++; if (v !== e) $display("FAIL simul_drain got %0d want %0d", v, e); else passed++;
  endtask

  task automatic test_empty();
    bit p; logic [7:0] e, v;
    step_a(0, 1'b0, 1, 1, 1, p, e, v);
    checks++; if (a_rd_err !== 1'b1) $display("FAIL empty_rd_err got %b want 1", a_rd_err); else passed++;
    checks++; if (a_count !== 2'd0) $display("FAIL empty_count got %0d want 0", a_count); else passed++;
    step_a(1, 1'b1, 0, 0, 1, p, e, v);
    checks++; if ({a_count, a_empty_n} !== 3'b000) $display("FAIL ce_mask got %b want 000", {a_count, a_empty_n}); else passed++;
    checks++; if ({a_wr_err, a_rd_err} !== {ewr_a, erd_a}) $display("FAIL empty_errs got %b want %b", {a_wr_err, a_rd_err}, {ewr_a, erd_a}); else passed++;
  endtask

  task automatic test_almost_full();
    bit p; logic [7:0] e, v;
    logic [3:0] want_af = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      step_b(1, 8'hA0 + 8'(i), 0, p, e, v);
      checks++; if (b_af !== want_af[i]) $display("FAIL af_push%0d got %b want %b", i, b_af, want_af[i]); else passed++;
      checks++; if (b_full_n !== (i != 3)) $display("FAIL full_push%0d got %b want %b", i, b_full_n, (i != 3)); else passed++;
    end
    step_b(1, 8'hFF, 1, p, e, v);
    checks++; if (!p || v !== e || e !== 8'hA0) $display("FAIL full_pop got %h want %h", v, e); else passed++;
    checks++; if ({b_count, b_full_n, b_wr_err} !== 5'b01111) $display("FAIL full_nobypass got %b want 01111", {b_count, b_full_n, b_wr_err}); else passed++;
  endtask

  task automatic test_back_to_back();
    bit p; logic [7:0] e, v;
    for (int i = 0; i < 60; i++) begin
      step_b(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), p, e, v);
      if (p) begin
        checks++; if (v !== e) $display("FAIL b2b_data[%0d] got %h want %h", i, v, e); else passed++;
      end
      checks++;
      if (b_count !== 3'(qb.size()) || b_empty_n !== (qb.size() != 0) ||
          b_full_n !== (qb.size() != 4) || b_af !== (qb.size() >= 3) ||
          b_wr_err !== ewr_b || b_rd_err !== erd_b)
        $display("FAIL b2b_state[%0d] got cnt=%0d e=%b f=%b af=%b we=%b re=%b want cnt=%0d",
                 i, b_count, b_empty_n, b_full_n, b_af, b_wr_err, b_rd_err, qb.size());
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    bit p; logic [7:0] e, v;
    for (int i = 0; i < 5; i++) step_b(1, 8'h30 + 8'(i), 0, p, e, v);
    reset_both();
    checks++; if ({b_count, b_empty_n, b_full_n, b_af} !== 6'b000010) $display("FAIL midrst_state got %b want 000010", {b_count, b_empty_n, b_full_n, b_af}); else passed++;
    checks++; if ({b_wr_err, b_rd_err} !== 2'b00) $display("FAIL midrst_err got %b want 00", {b_wr_err, b_rd_err}); else passed++;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_empty();
    test_almost_full();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
